// File: rtl/fib_num_gen.sv
// -----------------------------------------------------------------------------
// fib_num_gen
// Fibonacci sequence generator. A load pulse latches a seed (data_in) and an
// iteration count (order); the block then runs one Fibonacci step per clock
// starting from (prev,cur) = (0,data_in). It ends with exactly one of three
// one-cycle pulses:
//   done      - data_out holds the result
//   overflow  - a step carried out of DATA_WIDTH bits; data_out is all ones
//   error     - load arrived while busy; data_out is all x for that cycle,
//               then 0
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset; priority over everything
//   load      in   start request; data_in/order are sampled on the same edge
//   data_in   in   [DATA_WIDTH]  seed value
//   order     in   [ORDER_WIDTH] number of iterations
//   done      out  result pulse
//   overflow  out  saturation pulse
//   error     out  protocol-error pulse
//   busy      out  high while a computation is in progress
//   data_out  out  [DATA_WIDTH]  result (registered)
//
// Build option:
//   FIB_RESTART_EN - load while busy restarts the computation with the new
//                    operands instead of raising error. error then flags only
//                    a load sampled with X/Z on data_in or order
//                    (simulation-only check).
// -----------------------------------------------------------------------------
module fib_num_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int ORDER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [ORDER_WIDTH-1:0] order,
  output logic                   done,
  output logic                   overflow,
  output logic                   error,
  output logic                   busy,
  output logic [DATA_WIDTH-1:0]  data_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_OVF  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q,  data_d;
  logic [ORDER_WIDTH-1:0] order_q, order_d;
  logic [DATA_WIDTH-1:0]  prev_q,  prev_d;
  logic [DATA_WIDTH-1:0]  cur_q,   cur_d;
  logic [ORDER_WIDTH-1:0] cnt_q,   cnt_d;
  logic                   done_q,  done_d;
  logic                   ovf_q,   ovf_d;
  logic                   err_q,   err_d;
  logic                   busy_q,  busy_d;
  logic [DATA_WIDTH-1:0]  dout_q,  dout_d;

  // One extra bit so the carry out of a step is visible.
  logic [DATA_WIDTH:0] sum;
  logic                start;
  logic                bad_load;

  assign sum = {1'b0, prev_q} + {1'b0, cur_q};

`ifdef FIB_RESTART_EN
  assign bad_load = $isunknown(data_in) || $isunknown(order);
`else
  assign bad_load = 1'b0;
`endif

  // Next-state and output computation for the generator FSM.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    order_d = order_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    dout_d  = dout_q;
    start   = 1'b0;

    // The x shown with an error pulse lasts one cycle only.
    if (err_q) begin
      dout_d = {DATA_WIDTH{1'b0}};
    end else begin
      dout_d = dout_q;
    end

    case (state_q)
      S_IDLE: begin
        start = load;
      end
      S_INIT: begin
        prev_d = {DATA_WIDTH{1'b0}};
        cnt_d  = order_q;
        if ((data_q == {DATA_WIDTH{1'b0}}) || (order_q == {ORDER_WIDTH{1'b0}})) begin
          cur_d   = {DATA_WIDTH{1'b0}};
          state_d = S_DONE;
        end else begin
          cur_d   = data_q;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (sum[DATA_WIDTH]) begin
          // Saturate immediately on the carrying step; no wrap-around.
          ovf_d   = 1'b1;
          dout_d  = {DATA_WIDTH{1'b1}};
          busy_d  = 1'b0;
          state_d = S_OVF;
        end else begin
          prev_d = cur_q;
          cur_d  = sum[DATA_WIDTH-1:0];
          cnt_d  = cnt_q - ORDER_WIDTH'(1);
          if (cnt_q == ORDER_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        dout_d  = cur_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        start   = load;
      end
      S_OVF: begin
        state_d = S_IDLE;
        start   = load;
      end
      S_ERR: begin
        err_d   = 1'b1;
        dout_d  = {DATA_WIDTH{1'bx}};
        busy_d  = 1'b0;
        state_d = S_IDLE;
        start   = load;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A load while a computation is running aborts it.
    if (load && ((state_q == S_INIT) || (state_q == S_CALC))) begin
      ovf_d  = 1'b0;
      busy_d = 1'b1;
`ifdef FIB_RESTART_EN
      start  = 1'b1;
`else
      dout_d  = dout_q;
      state_d = S_ERR;
`endif
    end else begin
      busy_d = busy_d;
    end

    if (start && bad_load) begin
      ovf_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = S_ERR;
    end else if (start) begin
      data_d  = data_in;
      order_d = order;
      ovf_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = S_INIT;
      // A done/error pulse leaving on this edge keeps its own data_out.
      if ((state_q != S_DONE) && (state_q != S_ERR)) begin
        dout_d = {DATA_WIDTH{1'b0}};
      end else begin
        dout_d = dout_d;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= {DATA_WIDTH{1'b0}};
      order_q <= {ORDER_WIDTH{1'b0}};
      prev_q  <= {DATA_WIDTH{1'b0}};
      cur_q   <= {DATA_WIDTH{1'b0}};
      cnt_q   <= {ORDER_WIDTH{1'b0}};
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      order_q <= order_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign done     = done_q;
  assign overflow = ovf_q;
  assign error    = err_q;
  assign busy     = busy_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_fib_num_gen.sv
// -----------------------------------------------------------------------------
// tb_fib_num_gen
// Self-checking bench for fib_num_gen (DATA_WIDTH=64, ORDER_WIDTH=16).
// Expected results and latencies come from a plain-arithmetic Fibonacci model.
// -----------------------------------------------------------------------------
module tb_fib_num_gen;

  logic        clk;
  logic        reset;
  logic        load;
  logic [63:0] data_in;
  logic [15:0] order;
  logic        done;
  logic        overflow;
  logic        error;
  logic        busy;
  logic [63:0] data_out;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam int K_DONE = 0;
  localparam int K_OVF  = 1;
  localparam int K_ERR  = 2;

  fib_num_gen #(.DATA_WIDTH(64), .ORDER_WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .order    (order),
    .done     (done),
    .overflow (overflow),
    .error    (error),
    .busy     (busy),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: run `ord` steps of (a,b) <- (b,a+b) from (0,d) in 65-bit math.
  // Latency is counted in clock edges from the load edge to the visible pulse.
  task automatic ref_fib(input logic [63:0] d, input int ord,
                         output int kind, output logic [63:0] res, output int lat);
    logic [64:0] a;
    logic [64:0] b;
    logic [64:0] s;
    kind = K_DONE;
    res  = 64'd0;
    lat  = 2;
    if (d != 64'd0 && ord != 0) begin
      a   = 65'd0;
      b   = {1'b0, d};
      lat = ord + 2;
      for (int i = 1; i <= ord; i++) begin
        s = a + b;
        if (s > 65'h0_FFFF_FFFF_FFFF_FFFF) begin
          kind = K_OVF;
          res  = 64'hFFFF_FFFF_FFFF_FFFF;
          lat  = 1 + i;
          break;
        end
        a = b;
        b = s;
      end
      if (kind == K_DONE) res = b[63:0];
    end
  endtask

  // Present a one-cycle load; returns 1 ns after the sampling edge.
  task automatic launch(input logic [63:0] d, input logic [15:0] o);
    load    = 1'b1;
    data_in = d;
    order   = o;
    tick();
    load    = 1'b0;
  endtask

  // Count edges until a pulse appears (bounded).
  task automatic wait_pulse(output int n);
    n = 0;
    while (!(done || overflow || error) && n < 400) begin
      tick();
      n++;
    end
  endtask

  // Wait for and check the outcome of the load just launched.
  task automatic expect_result(input string tag, input int kind,
                               input logic [63:0] res, input int lat);
    int n;
    wait_pulse(n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_done"}, {63'd0, done}, {63'd0, kind == K_DONE});
    chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, kind == K_OVF});
    chk({tag, "_err"}, {63'd0, error}, {63'd0, kind == K_ERR});
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    if (kind != K_ERR) chk({tag, "_data"}, data_out, res);
  endtask

  // One cycle after a pulse every flag must be low again.
  task automatic expect_quiet(input string tag);
    tick();
    chk({tag, "_pulse_low"}, {61'd0, done, overflow, error}, 64'd0);
    chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int          kind;
    int          lat;
    int          pulses;
    logic [63:0] res;
    logic [63:0] d;
    int          o;

    reset   = 1'b1;
    load    = 1'b0;
    data_in = 64'd0;
    order   = 16'd0;
    tick();
    tick();
    chk("reset_flags", {60'd0, done, overflow, error, busy}, 64'd0);
    chk("reset_data", data_out, 64'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a long computation.
    launch(64'd1, 16'd20);
    repeat (5) tick();
    chk("midcalc_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    chk("midreset_flags", {60'd0, done, overflow, error, busy}, 64'd0);
    chk("midreset_data", data_out, 64'd0);
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || overflow || error || busy) pulses++;
    end
    chk("midreset_silent", 64'(pulses), 64'd0);

    // Directed values.
    launch(64'd1, 16'd5);
    expect_result("fib_1_5", K_DONE, 64'd8, 7);
    expect_quiet("fib_1_5");

    launch(64'd3, 16'd0);
    expect_result("order_zero", K_DONE, 64'd0, 2);
    expect_quiet("order_zero");

    launch(64'd0, 16'd10);
    expect_result("seed_zero", K_DONE, 64'd0, 2);
    expect_quiet("seed_zero");

    launch(64'd1, 16'd92);
    expect_result("fib_1_92", K_DONE, 64'd12200160415121876738, 94);
    expect_quiet("fib_1_92");

    launch(64'd1, 16'd93);
    expect_result("fib_1_93", K_OVF, 64'hFFFF_FFFF_FFFF_FFFF, 94);
    expect_quiet("fib_1_93");
    chk("ovf_data_hold", data_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // Load while busy: second load is sampled three edges after the first.
    launch(64'd1, 16'd10);
    tick();
    tick();
    launch(64'd2, 16'd4);
`ifdef FIB_RESTART_EN
    ref_fib(64'd2, 4, kind, res, lat);
    expect_result("restart", kind, res, lat);
    chk("restart_value", res, 64'd10);
    expect_quiet("restart");
`else
    expect_result("busy_load", K_ERR, 64'd0, 1);
    expect_quiet("busy_load");
    chk("err_data_clear", data_out, 64'd0);
`endif

    // Back-to-back: second load presented while done is high.
    ref_fib(64'd1, 5, kind, res, lat);
    launch(64'd1, 16'd5);
    expect_result("b2b_first", kind, res, lat);
    ref_fib(64'd2, 3, kind, res, lat);
    launch(64'd2, 16'd3);
    // launch already consumed the load edge, so the remaining wait is lat.
    expect_result("b2b_second", kind, res, lat);
    expect_quiet("b2b_second");

    // Randomized operands against the reference model.
    for (int t = 0; t < 12; t++) begin
      d = {$urandom(), $urandom()} >> $urandom_range(63, 0);
      o = $urandom_range(95, 0);
      if (t % 4 == 3) d = 64'd0;
      ref_fib(d, o, kind, res, lat);
      launch(d, 16'(o));
      expect_result($sformatf("rand%0d", t), kind, res, lat);
      expect_quiet($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
